fifo_rd_packer: RTL and testbench

- Read-clock-domain consumer of the async FIFO.
- Pops DW-bit entries whenever the FIFO is non-empty and packs RATIO consecutive entries into one wide word, filling the LSB lane first.
- Presents each word on a valid/ready output stream.
- A flush request emits a partial word with a byte-keep mask, so the tail of a packet is never stranded in the packer.

---
 rtl/fifo_rd_packer.sv | 144 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side consumer of the async FIFO. Pops DW-bit entries while the FIFO is
// non-empty and packs RATIO of them into one wide word, lane 0 first. A flush
// request emits the current partial word with a keep mask.
//
// State | meaning
// RUN   | normal packing, reads issued while there is room in the pack register
// FLUSH | reads held off; drain in-flight byte, then emit partial word
//
// Ports
//   rdclk, rdrst      clock / synchronous active-high reset
//   empty, rden       FIFO empty flag in, read enable out (combinational)
//   rddata            FIFO data, valid the cycle after rden
//   flush             single-cycle request to emit the partial word
//   out_valid/ready   output stream handshake
//   out_data/keep     packed word and lane-valid mask
//   busy              packer holds data, has a read in flight or flush pending
//   word_cnt          accepted output words, wraps
module fifo_rd_packer #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int CW    = 16
) (
  input  logic                rdclk,
  input  logic                rdrst,
  input  logic                empty,
  output logic                rden,
  input  logic [DW-1:0]       rddata,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*RATIO-1:0] out_data,
  output logic [RATIO-1:0]    out_keep,
  output logic                busy,
  output logic [CW-1:0]       word_cnt
);

  localparam int PCW = $clog2(RATIO + 1);
  localparam int WW  = DW * RATIO;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    pack_q, pack_d;
  logic [PCW-1:0]   pack_cnt_q, pack_cnt_d;
  logic             inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  logic [WW-1:0]    out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;

  logic             rden_c;
  logic             out_free;
  logic             xfer;
  logic             move;
  logic [RATIO-1:0] keep_mask;

  always_comb begin
    state_d     = state_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    word_cnt_d  = word_cnt_q;
    keep_mask   = '0;

    out_free = ~out_valid_q | out_ready;
    xfer     = out_valid_q & out_ready;

    // Count the in-flight byte as occupied so a read is never issued without room.
    rden_c = ~rdrst & ~empty & (state_q == RUN) &
             (({1'b0, pack_cnt_q} + {{PCW{1'b0}}, inflight_q}) < (PCW+1)'(RATIO));
    inflight_d = rden_c;

    if (inflight_q) begin
      for (int i = 0; i < RATIO; i++) begin
        if (pack_cnt_q == PCW'(i)) pack_d[i*DW +: DW] = rddata;
      end
      pack_cnt_d = pack_cnt_q + PCW'(1);
    end

    for (int i = 0; i < RATIO; i++) begin
      keep_mask[i] = (PCW'(i) < pack_cnt_q);
    end

    // A move never coincides with a capture: both move forms need inflight=0.
    move = out_free & ((pack_cnt_q == PCW'(RATIO)) |
                       ((state_q == FLUSH) & ~inflight_q));

    if (move) begin
      out_data_d  = pack_q;
      out_keep_d  = keep_mask;
      out_valid_d = 1'b1;
      pack_d      = '0;
      pack_cnt_d  = '0;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    if (xfer) word_cnt_d = word_cnt_q + CW'(1);

    case (state_q)
      RUN: begin
        // A full word leaving this cycle empties the packer; the flush has nothing to add.
        if (flush & (((pack_cnt_q != '0) & ~move) | inflight_q)) state_d = FLUSH;
      end
      FLUSH: begin
        if (move) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      state_q     <= RUN;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign rden      = rden_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign word_cnt  = word_cnt_q;
  assign busy      = (pack_cnt_q != '0) | inflight_q | (state_q == FLUSH) | out_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  localparam int DW = 8, RATIO = 4, CW = 16;

  logic             rdclk = 1'b0;
  logic             rdrst = 1'b1;
  logic             empty = 1'b1;
  logic             rden;
  logic [DW-1:0]    rddata = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [RATIO-1:0] out_keep;
  logic             busy;
  logic [CW-1:0]    word_cnt;

  fifo_rd_packer #(.DW(DW), .RATIO(RATIO), .CW(CW)) dut (
    .rdclk(rdclk), .rdrst(rdrst), .empty(empty), .rden(rden), .rddata(rddata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 rdclk = ~rdclk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [31:0] data; logic [3:0] keep; } word_t;
  word_t       sb[$];
  logic [7:0]  fifo_q[$];
  logic        rd_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: rddata appears the cycle after a sampled rden
  always @(negedge rdclk) rd_seen = rden;
  always @(posedge rdclk) begin
    logic fire;
    fire = rd_seen;
    #1;
    if (fire) begin
      if (fifo_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL underflow: read from empty fifo");
      end else rddata = fifo_q.pop_front();
    end
    empty = (fifo_q.size() == 0);
  end

  // Monitor: pop expected word on each transfer, check hold stability
  logic        hold_q = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_keep;
  always @(negedge rdclk) begin
    if (rdrst) hold_q = 1'b0;
    else begin
      if (hold_q && out_valid) begin
        chk("hold_data", out_data, hold_data);
        chk("hold_keep", out_keep, hold_keep);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_word: got 0x%08h keep %b expected none", out_data, out_keep);
        end else begin
          word_t e;
          e = sb.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_keep", out_keep, e.keep);
        end
      end
      hold_q    = out_valid && !out_ready;
      hold_data = out_data;
      hold_keep = out_keep;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge rdclk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!(busy === 1'b0 && empty === 1'b1 && sb.size() == 0) && k < 200) begin
      cyc(1); k++;
    end
    if (k >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: busy=%b empty=%b pending=%0d required idle", name, busy, empty, sb.size());
    end
    cyc(2);
  endtask

  task automatic wait_rden(input int count);
    int n, k;
    n = 0; k = 0;
    while (n < count && k < 100) begin
      @(negedge rdclk);
      if (rden) n++;
      k++;
    end
    if (n < count) begin
      n_tests++; n_fail++;
      $display("FAIL rden_timeout: saw %0d reads required %0d", n, count);
    end
  endtask

  initial begin
    // Reset with empty FIFO
    rdrst = 1'b1; out_ready = 1'b1;
    cyc(10);
    chk("rst_rden", rden, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_wcnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    rdrst = 1'b0;
    cyc(3);
    chk("idle_rden", rden, 0);
    chk("idle_busy", busy, 0);

    // One full word
    sb.push_back('{32'h44332211, 4'b1111});
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_idle("word1");
    chk("w1_wcnt", word_cnt, 1);
    chk("w1_rden", rden, 0);

    // Backpressure: two words, ready low until cycle 20
    out_ready = 1'b0;
    sb.push_back('{32'h04030201, 4'b1111});
    sb.push_back('{32'h08070605, 4'b1111});
    for (int i = 1; i <= 8; i++) push(8'(i));
    cyc(19);
    chk("bp_rden_stall", rden, 0);
    chk("bp_fifo_drained", empty, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_first_word", out_data, 32'h04030201);
    chk("bp_busy", busy, 1);
    cyc(1);
    out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_wcnt", word_cnt, 3);

    // Flush in the cycle the second byte lands
    sb.push_back('{32'h0000BBAA, 4'b0011});
    push(8'hAA); push(8'hBB);
    wait_rden(2);
    @(posedge rdclk); #1 flush = 1'b1;
    @(posedge rdclk); #1 flush = 1'b0;
    wait_idle("flush");
    chk("fl_wcnt", word_cnt, 4);
    chk("fl_busy_run", busy, 0);

    // Flush with nothing held: ignored
    @(posedge rdclk); #1 flush = 1'b1;
    @(posedge rdclk); #1 flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("idle_flush_valid", out_valid, 0);
    end
    chk("idle_flush_busy", busy, 0);
    chk("idle_flush_wcnt", word_cnt, 4);

    // Reset mid-word: pack_cnt=2 with third byte in flight
    push(8'hE1); push(8'hE2); push(8'hE3);
    wait_rden(3);
    @(posedge rdclk); #1 rdrst = 1'b1;
    chk("mid_busy_before", busy, 1);
    @(posedge rdclk); #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_keep", out_keep, 0);
    chk("mr_wcnt", word_cnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rden", rden, 0);
    rdrst = 1'b0;
    cyc(2);
    sb.push_back('{32'h58575655, 4'b1111});
    push(8'h55); push(8'h56); push(8'h57); push(8'h58);
    wait_idle("post_rst");
    chk("pr_wcnt", word_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
